// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/flush controller: per-stage pause vector, exception flush and fetch redirect.
// Optional stall/flush performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h1C000000,
   parameter logic [5:0]  IDLE_PAUSE = 6'b001111
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_req_if,
   input  logic        stall_req_id,
   input  logic        stall_req_ex,
   input  logic        stall_req_mem,
   input  logic        excp_req,
   input  logic [31:0] excp_target_pc,
   input  logic        ertn_req,
   input  logic [31:0] ertn_pc,
   input  logic        idle_req,
   input  logic        interrupt_pending,
   output logic [5:0]  pause,
   output logic        exception_flush,
   output logic        redirect_en,
   output logic [31:0] redirect_pc,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_IDLE} state_t;

   state_t      state_q, state_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        redirect_en_q, redirect_en_d;
   logic [5:0]  stall_pause;
   logic        any_stall;

   assign any_stall = stall_req_if | stall_req_id | stall_req_ex | stall_req_mem;

   // Deepest stalling stage wins; the stage after it sees a bubble because its bit stays clear.
   always_comb begin
      stall_pause = 6'b000000;
      if (stall_req_mem)     stall_pause = 6'b011111;
      else if (stall_req_ex) stall_pause = 6'b001111;
      else if (stall_req_id) stall_pause = 6'b000111;
      else if (stall_req_if) stall_pause = 6'b000011;
   end

   always_ff @(posedge clk) begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      redirect_en_q <= redirect_en_d;
   end

   always_comb begin
      state_d       = state_q;
      redirect_pc_d = redirect_pc_q;
      if (rst) begin
         state_d       = ST_RUN;
         redirect_pc_d = RESET_PC;
      end else begin
         unique case (state_q)
            ST_RUN: begin
               if (excp_req) begin
                  state_d       = ST_FLUSH;
                  redirect_pc_d = excp_target_pc;
               end else if (ertn_req) begin
                  state_d       = ST_FLUSH;
                  redirect_pc_d = ertn_pc;
               end else if (idle_req && !any_stall) begin
                  state_d = ST_IDLE;
               end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_IDLE: begin
               if (excp_req) begin
                  state_d       = ST_FLUSH;
                  redirect_pc_d = excp_target_pc;
               end else if (interrupt_pending) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
      // Registered so the pulse lines up exactly with the FLUSH state.
      redirect_en_d = (state_d == ST_FLUSH);
   end

   always_comb begin
      pause           = 6'b000000;
      exception_flush = 1'b0;
      if (!rst) begin
         unique case (state_q)
            ST_RUN: begin
               if (excp_req || ertn_req) exception_flush = 1'b1;
               else                      pause           = stall_pause;
            end
            ST_FLUSH: exception_flush = 1'b1;
            ST_IDLE: begin
               if (excp_req) exception_flush = 1'b1;
               else          pause           = IDLE_PAUSE;
            end
            default: ;
         endcase
      end
   end

   assign redirect_en = redirect_en_q;
   assign redirect_pc = redirect_pc_q;

`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   always_ff @(posedge clk) begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (rst) begin
         stall_cycles_d = 32'd0;
         flush_count_d  = 32'd0;
      end else begin
         if (pause != 6'b000000 && stall_cycles_q != 32'hFFFFFFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
         if (state_d == ST_FLUSH && state_q != ST_FLUSH && flush_count_q != 32'hFFFFFFFF)
            flush_count_d = flush_count_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`else
   assign stall_cycles = 32'd0;
   assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each step pushes the expected outputs for that cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_pipeline_ctrl;

   localparam logic [31:0] RST_PC = 32'h1C000000;
   localparam logic [31:0] PC_A   = 32'h1C008000;
   localparam logic [31:0] PC_B   = 32'h1C000100;
   localparam logic [31:0] PC_C   = 32'h1C000200;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
   logic        excp_req, ertn_req, idle_req, interrupt_pending;
   logic [31:0] excp_target_pc, ertn_pc;
   logic [5:0]  pause;
   logic        exception_flush, redirect_en;
   logic [31:0] redirect_pc, stall_cycles, flush_count;

   typedef struct {
      string       tag;
      logic [5:0]  pause;
      logic        flush;
      logic        ren;
      logic [31:0] rpc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .stall_req_if      (stall_req_if),
      .stall_req_id      (stall_req_id),
      .stall_req_ex      (stall_req_ex),
      .stall_req_mem     (stall_req_mem),
      .excp_req          (excp_req),
      .excp_target_pc    (excp_target_pc),
      .ertn_req          (ertn_req),
      .ertn_pc           (ertn_pc),
      .idle_req          (idle_req),
      .interrupt_pending (interrupt_pending),
      .pause             (pause),
      .exception_flush   (exception_flush),
      .redirect_en       (redirect_en),
      .redirect_pc       (redirect_pc),
      .stall_cycles      (stall_cycles),
      .flush_count       (flush_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.tag, ".pause"}, {26'd0, pause}, {26'd0, e.pause});
         check({e.tag, ".flush"}, {31'd0, exception_flush}, {31'd0, e.flush});
         check({e.tag, ".ren"}, {31'd0, redirect_en}, {31'd0, e.ren});
         check({e.tag, ".rpc"}, redirect_pc, e.rpc);
         $display("step %-10s pause=%b flush=%b ren=%b rpc=%h", e.tag, pause, exception_flush,
                  redirect_en, redirect_pc);
      end
   end

   // in = {rst, if, id, ex, mem, excp, ertn, idle, intr}
   task automatic step(input string tag, input logic [8:0] in, input logic [31:0] epc,
                       input logic [31:0] rpc_in, input logic [5:0] e_pause, input logic e_flush,
                       input logic e_ren, input logic [31:0] e_rpc);
      exp_t e;
      e.tag = tag; e.pause = e_pause; e.flush = e_flush; e.ren = e_ren; e.rpc = e_rpc;
      exp_q.push_back(e);
      {rst, stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
       excp_req, ertn_req, idle_req, interrupt_pending} = in;
      excp_target_pc = epc;
      ertn_pc        = rpc_in;
      @(posedge clk);
      #1;
   endtask

   task automatic check_counters(input string tag, input logic [31:0] e_stall, input logic [31:0] e_flush);
`ifdef PIPE_PERF_CNT_EN
      check({tag, ".stall_cycles"}, stall_cycles, e_stall);
      check({tag, ".flush_count"}, flush_count, e_flush);
`else
      check({tag, ".stall_cycles"}, stall_cycles, 32'd0 & e_stall);
      check({tag, ".flush_count"}, flush_count, 32'd0 & e_flush);
`endif
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      {rst, stall_req_if, stall_req_id, stall_req_ex, stall_req_mem,
       excp_req, ertn_req, idle_req, interrupt_pending} = 9'b1_0000_0000;
      excp_target_pc = 32'd0;
      ertn_pc        = 32'd0;
      repeat (2) @(posedge clk);
      #1;

      step("rst",      9'b1_0001_1000, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, RST_PC);
      step("run0",     9'b0_0000_0000, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, RST_PC);
      check_counters("after_rst", 32'd0, 32'd0);
      for (int i = 0; i < 3; i++)
         step("id_stall", 9'b0_0100_0000, PC_A, PC_C, 6'b000111, 1'b0, 1'b0, RST_PC);
      step("id_rel",   9'b0_0000_0000, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, RST_PC);
      step("if_ex_mem",9'b0_1011_0000, PC_A, PC_C, 6'b011111, 1'b0, 1'b0, RST_PC);
      step("if_ex",    9'b0_1010_0000, PC_A, PC_C, 6'b001111, 1'b0, 1'b0, RST_PC);
      step("if_only",  9'b0_1000_0000, PC_A, PC_C, 6'b000011, 1'b0, 1'b0, RST_PC);

      step("excp_mem", 9'b0_0001_1000, PC_A, PC_C, 6'b000000, 1'b1, 1'b0, RST_PC);
      step("flush1",   9'b0_0001_0100, PC_B, PC_C, 6'b000000, 1'b1, 1'b1, PC_A);
      step("back_run", 9'b0_0000_0000, PC_B, PC_C, 6'b000000, 1'b0, 1'b0, PC_A);

      step("excp_ertn",9'b0_0000_1100, PC_B, PC_C, 6'b000000, 1'b1, 1'b0, PC_A);
      step("flush2",   9'b0_0000_0000, PC_B, PC_C, 6'b000000, 1'b1, 1'b1, PC_B);
      step("ertn",     9'b0_0000_0100, PC_B, PC_C, 6'b000000, 1'b1, 1'b0, PC_B);
      step("flush3",   9'b0_0000_0000, PC_B, PC_C, 6'b000000, 1'b1, 1'b1, PC_C);

      step("idle_stl", 9'b0_0100_0010, PC_A, PC_C, 6'b000111, 1'b0, 1'b0, PC_C);
      step("idle_req", 9'b0_0000_0010, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, PC_C);
      step("idle1",    9'b0_0000_0000, PC_A, PC_C, 6'b001111, 1'b0, 1'b0, PC_C);
      step("idle_mem", 9'b0_0001_0000, PC_A, PC_C, 6'b001111, 1'b0, 1'b0, PC_C);
      step("idle3",    9'b0_0000_0000, PC_A, PC_C, 6'b001111, 1'b0, 1'b0, PC_C);
      step("idle_int", 9'b0_0000_0001, PC_A, PC_C, 6'b001111, 1'b0, 1'b0, PC_C);
      step("wake",     9'b0_0000_0000, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, PC_C);
      step("idle_req2",9'b0_0000_0010, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, PC_C);
      step("idle_exc", 9'b0_0000_1000, PC_A, PC_C, 6'b000000, 1'b1, 1'b0, PC_C);
      step("flush4",   9'b0_0000_0000, PC_A, PC_C, 6'b000000, 1'b1, 1'b1, PC_A);
      step("run1",     9'b0_0000_0000, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, PC_A);

      step("rst2",     9'b1_0000_0000, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, PC_A);
      step("run2",     9'b0_0000_0000, PC_A, PC_C, 6'b000000, 1'b0, 1'b0, RST_PC);
      check_counters("rst2", 32'd0, 32'd0);
      for (int i = 0; i < 5; i++)
         step("mem_stall", 9'b0_0001_0000, PC_A, PC_C, 6'b011111, 1'b0, 1'b0, RST_PC);
      step("excp5",    9'b0_0000_1000, PC_B, PC_C, 6'b000000, 1'b1, 1'b0, RST_PC);
      step("flush5",   9'b0_0000_0000, PC_B, PC_C, 6'b000000, 1'b1, 1'b1, PC_B);
      step("ertn6",    9'b0_0000_0100, PC_B, PC_C, 6'b000000, 1'b1, 1'b0, PC_B);
      check_counters("perf", 32'd5, 32'd2);
      step("rst_flush",9'b1_0000_0000, PC_B, PC_C, 6'b000000, 1'b0, 1'b1, PC_C);
      step("post_rst", 9'b0_0000_0000, PC_B, PC_C, 6'b000000, 1'b0, 1'b0, RST_PC);
      check_counters("post_rst", 32'd0, 32'd0);

      @(negedge clk);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
